fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencer for the `instructionFetch` stage. It drives the fetch unit's `en`, `branchFlag` and `branchAddr` inputs and the flush controls of the IF/ID and ID/EX pipeline buffers. It arbitrates three requests: branch redirects from execute, load-use stalls from decode, and halt. It sits between the hazard/branch logic and `instructionFetch`.

## Interface
- `ADDR_W`, 24: fetch address width; matches `branchAddr`.
- `RESET_ADDR`, 0: PC loaded into fetch by the boot redirect.
- `FLUSH_CYCLES`, 2: bubble cycles after a taken branch. Legal range 1..7.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stallReq`  in  1: decode hazard; hold fetch and insert a bubble.
- `branchTaken`  in  1: execute resolved a taken branch this cycle.
- `branchTarget`  in  ADDR_W: target for `branchTaken`.
- `haltReq`  in  1: halt instruction decoded.
- `fetchEn`  out  1: to fetch `en`.
- `branchFlag`  out  1: to fetch `branchFlag`.
- `branchAddr`  out  ADDR_W: to fetch `branchAddr`.
- `flushIfId`  out  1: clear the IF/ID buffer.
- `flushIdEx`  out  1: clear the ID/EX buffer (bubble).
- `halted`  out  1: the core is halted.
- `stallCount`  out  16: stall cycles; performance feature.
- `redirectCount`  out  16: taken redirects; performance feature.

## Operation
- States: RESET, BOOT, RUN, STALL, REDIRECT, HALT. A 3-bit down-counter `flushCnt` is used in REDIRECT.
- Outputs are combinational from the current state and the inputs (Mealy). This lets a redirect reach the fetch unit in the cycle the branch resolves.
- RESET: all outputs 0.
  - Entered asynchronously on `rst`.
  - The first rising edge with `rst` low moves to BOOT.
- BOOT (one cycle):
  - Outputs: `fetchEn`=1, `branchFlag`=1, `branchAddr`=RESET_ADDR, both flushes 1.
  - Next state: RUN.
- RUN: `fetchEn`=1, all other outputs 0. Request priority, same in RUN and STALL:
  - `branchTaken` has highest priority. Same cycle: `branchFlag`=1, `branchAddr`=`branchTarget`, `fetchEn`=1, both flushes 1. Then `flushCnt`←FLUSH_CYCLES and the state moves to REDIRECT.
  - `haltReq` is next. Same cycle: `fetchEn`=0, `flushIfId`=1. Next state HALT.
  - `stallReq` is lowest. Same cycle: `fetchEn`=0, `flushIdEx`=1. Next state STALL.
- STALL: same outputs as the `stallReq` case, as long as `stallReq` is high.
  - `stallReq` low with no branch or halt: `fetchEn`=1 this cycle, next state RUN.
  - A branch in STALL ends the stall and redirects.
- REDIRECT:
  - Outputs: `fetchEn`=1, `flushIdEx`=1, `branchFlag`=0.
  - `branchTaken`, `stallReq` and `haltReq` are ignored; they come from squashed instructions.
  - `flushCnt` decrements each cycle. When it reaches 1, next state RUN.
- HALT: `fetchEn`=0, `flushIfId`=1, `halted`=1. Only `rst` exits.
- `branchAddr` is 0 whenever `branchFlag`=0.

## Timing
- Branch-to-redirect latency: 0 cycles. The fetch unit samples the new PC at the next rising edge.
- A taken branch costs exactly 1 + FLUSH_CYCLES cycles with `flushIdEx` high.
- A stall lasting N cycles of `stallReq` holds `fetchEn` low for exactly N cycles.
- Asserting `rst` mid-REDIRECT or mid-STALL returns to RESET at once.
  - Outputs go to 0 without waiting for a clock.
  - Counters clear to 0.
- Simultaneous `branchTaken`, `haltReq` and `stallReq`: the branch wins. Halt and stall are dropped.

## Configuration
- `FETCH_CTRL_PERF_EN` defined:
  - `stallCount` increments each cycle spent in STALL, including the entry cycle.
  - `redirectCount` increments on each accepted `branchTaken`. The BOOT redirect is not counted.
  - Both counters are 16-bit and saturate at 16'hFFFF.
- Not defined: both counter outputs are constant 0 and no counter flops are built.

## Structure
- `fetch_ctrl_pkg` holds:
  - the `fetch_state_t` enum;
  - `ADDR_W_DEF`=24;
  - `PERF_W`=16.
- One sub-module, `fetch_ctrl_sat_counter` (width-parameterised saturating counter with increment enable). It is instantiated twice, inside the `FETCH_CTRL_PERF_EN` guard.

## Test plan
All scenarios use RESET_ADDR=0, FLUSH_CYCLES=2, and `FETCH_CTRL_PERF_EN` defined.
- Reset release:
  - Stimulus: `rst`=1 for 2 cycles, then `rst`=0.
  - Response: all outputs 0 during reset.
  - Next cycle: `branchFlag`=1, `branchAddr`=0, both flushes 1.
  - Then RUN with `fetchEn`=1.
- Branch:
  - Stimulus: in RUN, `branchTaken`=1, `branchTarget`=12 for 1 cycle.
  - Response: same cycle `branchFlag`=1, `branchAddr`=12.
  - `flushIdEx` high for 3 cycles total; `redirectCount`=1.
- Branch during REDIRECT:
  - Stimulus: `branchTaken`=1 held for 3 cycles.
  - Response: only the first cycle is accepted; `redirectCount`=1.
- Stall:
  - Stimulus: `stallReq` high for 3 cycles.
  - Response: `fetchEn`=0 and `flushIdEx`=1 for exactly 3 cycles; `stallCount`=3.
- Priority:
  - Stimulus: `branchTaken`, `haltReq` and `stallReq` all high in the same cycle, `branchTarget`=16.
  - Response: redirect to 16; `halted` stays 0.
- Halt, then reset mid-REDIRECT:
  - Stimulus: `haltReq`; later, `rst` pulsed during REDIRECT.
  - Response to `haltReq`: `halted`=1 and `fetchEn`=0 until `rst`.
  - Response to the `rst` pulse: outputs go to 0 asynchronously and counters read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional performance counters are enabled by FETCH_CTRL_PERF_EN.
package fetch_ctrl_pkg;

   localparam int ADDR_W_DEF = 24;
   localparam int PERF_W     = 16;
   localparam int FCNT_W     = 3;

   typedef enum logic [2:0] {
      S_RESET,
      S_BOOT,
      S_RUN,
      S_STALL,
      S_REDIRECT,
      S_HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with increment enable.
// Used for the optional FETCH_CTRL_PERF_EN stall/redirect counters.
module fetch_ctrl_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: arbitrates branch, halt and stall requests into fetch controls.
// Define FETCH_CTRL_PERF_EN to build the stall/redirect performance counters.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W       = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_ADDR   = '0,
   parameter int                FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallReq,
   input  logic              branchTaken,
   input  logic [ADDR_W-1:0] branchTarget,
   input  logic              haltReq,
   output logic              fetchEn,
   output logic              branchFlag,
   output logic [ADDR_W-1:0] branchAddr,
   output logic              flushIfId,
   output logic              flushIdEx,
   output logic              halted,
   output logic [PERF_W-1:0] stallCount,
   output logic [PERF_W-1:0] redirectCount
);

   localparam logic [FCNT_W-1:0] FLUSH_LD = FCNT_W'(FLUSH_CYCLES);

   fetch_state_t      r_state;
   fetch_state_t      w_next_state;
   logic [FCNT_W-1:0] r_flush_cnt;
   logic [FCNT_W-1:0] w_next_cnt;

   logic w_req_ok;
   logic w_take_br;
   logic w_take_halt;
   logic w_take_stall;

   // Requests are only honoured in RUN/STALL; in REDIRECT they are squashed.
   assign w_req_ok     = (r_state == S_RUN) || (r_state == S_STALL);
   assign w_take_br    = w_req_ok & branchTaken;
   assign w_take_halt  = w_req_ok & ~branchTaken & haltReq;
   assign w_take_stall = w_req_ok & ~branchTaken & ~haltReq & stallReq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_RESET;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_flush_cnt <= w_next_cnt;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_flush_cnt;
      case (r_state)
         S_RESET: w_next_state = S_BOOT;
         S_BOOT:  w_next_state = S_RUN;
         S_RUN, S_STALL: begin
            unique case (1'b1)
               w_take_br: begin
                  w_next_state = S_REDIRECT;
                  w_next_cnt   = FLUSH_LD;
               end
               w_take_halt:  w_next_state = S_HALT;
               w_take_stall: w_next_state = S_STALL;
               default:      w_next_state = S_RUN;
            endcase
         end
         S_REDIRECT: begin
            if (r_flush_cnt <= FCNT_W'(1)) begin
               w_next_state = S_RUN;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt = r_flush_cnt - 1'b1;
            end
         end
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_RESET;
      endcase
   end

   always_comb begin
      fetchEn    = 1'b0;
      branchFlag = 1'b0;
      branchAddr = '0;
      flushIfId  = 1'b0;
      flushIdEx  = 1'b0;
      halted     = 1'b0;
      case (r_state)
         S_BOOT: begin
            fetchEn    = 1'b1;
            branchFlag = 1'b1;
            branchAddr = RESET_ADDR;
            flushIfId  = 1'b1;
            flushIdEx  = 1'b1;
         end
         S_RUN, S_STALL: begin
            unique case (1'b1)
               w_take_br: begin
                  fetchEn    = 1'b1;
                  branchFlag = 1'b1;
                  branchAddr = branchTarget;
                  flushIfId  = 1'b1;
                  flushIdEx  = 1'b1;
               end
               w_take_halt:  flushIfId = 1'b1;
               w_take_stall: flushIdEx = 1'b1;
               default:      fetchEn   = 1'b1;
            endcase
         end
         S_REDIRECT: begin
            fetchEn   = 1'b1;
            flushIdEx = 1'b1;
         end
         S_HALT: begin
            flushIfId = 1'b1;
            halted    = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef FETCH_CTRL_PERF_EN
   fetch_ctrl_sat_counter #(.W(PERF_W)) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_take_stall),
      .o_count (stallCount)
   );

   fetch_ctrl_sat_counter #(.W(PERF_W)) u_redir_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_take_br),
      .o_count (redirectCount)
   );
`else
   assign stallCount    = '0;
   assign redirectCount = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// checked each cycle against a request-level behavioural model.
module tb_fetch_ctrl;

   localparam int AW    = 24;
   localparam int FLUSH = 2;
`ifdef FETCH_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          stallReq;
   logic          branchTaken;
   logic [AW-1:0] branchTarget;
   logic          haltReq;
   logic          fetchEn;
   logic          branchFlag;
   logic [AW-1:0] branchAddr;
   logic          flushIfId;
   logic          flushIdEx;
   logic          halted;
   logic [15:0]   stallCount;
   logic [15:0]   redirectCount;

   int n_vec = 0;
   int n_err = 0;

   // model: cycles since reset release, redirect bubbles left, halt flag, counts
   int m_age = 0;
   int m_bub = 0;
   bit m_hlt = 1'b0;
   int m_sc  = 0;
   int m_rc  = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(
      .ADDR_W       (AW),
      .RESET_ADDR   (24'd0),
      .FLUSH_CYCLES (FLUSH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallReq      (stallReq),
      .branchTaken   (branchTaken),
      .branchTarget  (branchTarget),
      .haltReq       (haltReq),
      .fetchEn       (fetchEn),
      .branchFlag    (branchFlag),
      .branchAddr    (branchAddr),
      .flushIfId     (flushIfId),
      .flushIdEx     (flushIdEx),
      .halted        (halted),
      .stallCount    (stallCount),
      .redirectCount (redirectCount)
   );

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_age = 0;
      m_bub = 0;
      m_hlt = 1'b0;
      m_sc  = 0;
      m_rc  = 0;
   endtask

   function automatic int sat(input int v);
      return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
   endfunction

   // Expected outputs for the current inputs, then advance the model one edge.
   task automatic check_model();
      bit          e_fe, e_bf, e_fi, e_fx, e_h;
      logic [AW-1:0] e_ba;
      int          e_sc, e_rc;
      e_fe = 0; e_bf = 0; e_fi = 0; e_fx = 0; e_h = 0; e_ba = '0;
      if (rst) model_reset();
      e_sc = PERF ? m_sc : 0;
      e_rc = PERF ? m_rc : 0;
      if (rst) begin
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (m_age == 1) begin
         e_fe = 1; e_bf = 1; e_fi = 1; e_fx = 1;
         m_age = 2;
      end else if (m_bub > 0) begin
         e_fe = 1; e_fx = 1;
         m_bub--;
      end else if (m_hlt) begin
         e_fi = 1; e_h = 1;
      end else if (branchTaken) begin
         e_fe = 1; e_bf = 1; e_ba = branchTarget; e_fi = 1; e_fx = 1;
         m_bub = FLUSH;
         m_rc  = sat(m_rc);
      end else if (haltReq) begin
         e_fi  = 1;
         m_hlt = 1'b1;
      end else if (stallReq) begin
         e_fx = 1;
         m_sc = sat(m_sc);
      end else begin
         e_fe = 1;
      end
      cmp("fetchEn",       32'(fetchEn),       32'(e_fe));
      cmp("branchFlag",    32'(branchFlag),    32'(e_bf));
      cmp("branchAddr",    32'(branchAddr),    32'(e_ba));
      cmp("flushIfId",     32'(flushIfId),     32'(e_fi));
      cmp("flushIdEx",     32'(flushIdEx),     32'(e_fx));
      cmp("halted",        32'(halted),        32'(e_h));
      cmp("stallCount",    32'(stallCount),    32'(e_sc));
      cmp("redirectCount", 32'(redirectCount), 32'(e_rc));
   endtask

   task automatic step(input bit r, input bit s, input bit b,
                       input logic [AW-1:0] t, input bit h);
      @(posedge clk);
      #1;
      rst          = r;
      stallReq     = s;
      branchTaken  = b;
      branchTarget = t;
      haltReq      = h;
      @(negedge clk);
      check_model();
   endtask

   task automatic idle();
      step(0, 0, 0, '0, 0);
   endtask

   // Pulse rst between edges and check the outputs drop without a clock.
   task automatic async_rst_check(input string nm);
      #2;
      rst = 1'b1;
      #1;
      cmp({nm, "_fetchEn"},    32'(fetchEn),       0);
      cmp({nm, "_flushIdEx"},  32'(flushIdEx),     0);
      cmp({nm, "_flushIfId"},  32'(flushIfId),     0);
      cmp({nm, "_stallCount"}, 32'(stallCount),    0);
      cmp({nm, "_redirCount"}, 32'(redirectCount), 0);
      model_reset();
      step(1, 0, 0, '0, 0);
      idle();
      idle();
   endtask

   initial begin
      rst = 1'b1; stallReq = 0; branchTaken = 0;
      branchTarget = '0; haltReq = 0;

      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
      cmp("lit_rst_fetchEn", 32'(fetchEn), 0);
      idle();
      idle();
      cmp("lit_boot_branchFlag", 32'(branchFlag), 1);
      cmp("lit_boot_flushIfId",  32'(flushIfId),  1);
      idle();
      cmp("lit_run_fetchEn", 32'(fetchEn), 1);

      step(0, 0, 1, 24'd12, 0);
      cmp("lit_br_branchAddr", 32'(branchAddr), 12);
      cmp("lit_br_branchFlag", 32'(branchFlag), 1);
      idle();
      idle();
      cmp("lit_redir_flushIdEx", 32'(flushIdEx), 1);
      idle();
      cmp("lit_after_flushIdEx", 32'(flushIdEx), 0);
      cmp("lit_redirectCount1", 32'(redirectCount), PERF ? 1 : 0);

      repeat (3) step(0, 0, 1, 24'd20, 0);
      idle();
      cmp("lit_redirectCount2", 32'(redirectCount), PERF ? 2 : 0);

      repeat (3) step(0, 1, 0, '0, 0);
      cmp("lit_stall_fetchEn", 32'(fetchEn), 0);
      idle();
      cmp("lit_unstall_fetchEn", 32'(fetchEn), 1);
      cmp("lit_stallCount3", 32'(stallCount), PERF ? 3 : 0);

      step(0, 1, 1, 24'd16, 1);
      cmp("lit_prio_branchAddr", 32'(branchAddr), 16);
      cmp("lit_prio_halted",     32'(halted),     0);
      idle();
      idle();
      idle();

      step(0, 0, 0, '0, 1);
      cmp("lit_halt_fetchEn", 32'(fetchEn), 0);
      idle();
      idle();
      cmp("lit_halted", 32'(halted), 1);

      step(1, 0, 0, '0, 0);
      idle();
      idle();
      idle();
      step(0, 0, 1, 24'd8, 0);
      idle();
      async_rst_check("arst_redir");
      idle();
      step(0, 1, 0, '0, 0);
      step(0, 1, 0, '0, 0);
      async_rst_check("arst_stall");

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(63) == 0),
              ($urandom_range(2) == 0),
              ($urandom_range(5) == 0),
              AW'($urandom),
              ($urandom_range(39) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
